// File: rtl/uart_doc_tx.sv
// Streams a document buffer out over an 8N1 UART line, inserting CR/LF after
// every ROW_LEN characters; one dump per accepted start pulse.
module uart_doc_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 9,
  parameter int DOC_DEPTH    = 512,
  parameter int ROW_LEN      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              read_enable,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int COL_W = $clog2(ROW_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DOC_DEPTH - 1);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(ROW_LEN);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_START, ST_DATA, ST_STOP, ST_NEXT, ST_FINISH
  } state_t;

  // Which byte the current frame carries: a document character or the row break.
  typedef enum logic [1:0] {PH_DOC, PH_CR, PH_LF} phase_t;

  state_t            state_r, state_s;
  phase_t            phase_r, phase_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        bit_r, bit_s;
  logic [7:0]        shift_r, shift_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic              tx_r, tx_s;
  logic              busy_r, busy_s;
  logic              rden_r, rden_s;
  logic              done_r, done_s;
  logic              bit_end_s;
  logic [COL_W-1:0]  col_inc_s;

  assign bit_end_s   = (cnt_r == CNT_LAST);
  assign col_inc_s   = col_r + COL_W'(1);
  assign rd_addr     = addr_r;
  assign read_enable = rden_r;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state and next-output logic; tx is computed one edge ahead so it is a flop.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    addr_s  = addr_r;
    col_s   = col_r;
    tx_s    = tx_r;
    busy_s  = busy_r;
    rden_s  = rden_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        rden_s = 1'b0;
        if (start) begin
          state_s = ST_FETCH;
          phase_s = PH_DOC;
          addr_s  = '0;
          col_s   = '0;
          cnt_s   = '0;
          bit_s   = 3'd0;
          busy_s  = 1'b1;
          rden_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        shift_s = rd_data;
        tx_s    = 1'b0;
        cnt_s   = '0;
        state_s = ST_START;
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
          state_s = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = ST_STOP;
          end else begin
            bit_s = bit_r + 3'd1;
            tx_s  = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = ST_NEXT;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        case (phase_r)
          PH_DOC: begin
            col_s = col_inc_s;
            if (col_inc_s == COL_END) begin
              phase_s = PH_CR;
              shift_s = 8'h0D;
              tx_s    = 1'b0;
              cnt_s   = '0;
              state_s = ST_START;
            end else if (addr_r == ADDR_LAST) begin
              done_s  = 1'b1;
              state_s = ST_FINISH;
            end else begin
              addr_s  = addr_r + ADDR_W'(1);
              state_s = ST_FETCH;
            end
          end
          PH_CR: begin
            phase_s = PH_LF;
            shift_s = 8'h0A;
            tx_s    = 1'b0;
            cnt_s   = '0;
            state_s = ST_START;
          end
          PH_LF: begin
            phase_s = PH_DOC;
            col_s   = '0;
            if (addr_r == ADDR_LAST) begin
              done_s  = 1'b1;
              state_s = ST_FINISH;
            end else begin
              addr_s  = addr_r + ADDR_W'(1);
              state_s = ST_FETCH;
            end
          end
          default: begin
            phase_s = PH_DOC;
            tx_s    = 1'b1;
            busy_s  = 1'b0;
            rden_s  = 1'b0;
            state_s = ST_IDLE;
          end
        endcase
      end
      ST_FINISH: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        rden_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        rden_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to an idle, high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= PH_DOC;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      addr_r  <= '0;
      col_r   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      rden_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      addr_r  <= addr_s;
      col_r   <= col_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      rden_r  <= rden_s;
      done_r  <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_doc_tx.sv
// Directed bench for uart_doc_tx: reset/start vector table, serial decode of whole
// dumps, bit timing, mid-frame reset and start-while-busy/at-done corner cases.
module tb_uart_doc_tx;
  localparam int CPB    = 4;
  localparam int AW     = 9;
  localparam int DEPTH  = 64;
  localparam int RL     = 32;
  localparam int NBYTES = 68;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          read_enable;
  logic          tx;
  logic          busy;
  logic          done;

  logic [7:0] mem [DEPTH];
  int total = 0;
  int bad   = 0;

  assign rd_data = mem[rd_addr[5:0]];
  always #5 clk = ~clk;

  uart_doc_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DOC_DEPTH(DEPTH), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .read_enable(read_enable), .tx(tx), .busy(busy), .done(done)
  );

  // Serial decoder: sample index 0 is the first low sample of the start bit.
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = 8'h00;
  int         frames_started = 0;
  int         frame_err = 0;
  int         done_cnt = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      dec_active <= 1'b0;
      dec_cnt    <= 0;
    end else if (!dec_active) begin
      if (tx === 1'b0) begin
        dec_active     <= 1'b1;
        dec_cnt        <= 1;
        frames_started <= frames_started + 1;
      end
    end else begin
      if (dec_cnt >= 5 && dec_cnt <= 33 && (dec_cnt % 4) == 1)
        dec_sh[(dec_cnt - 5) / 4] <= tx;
      if (dec_cnt == 37) begin
        dec_active <= 1'b0;
        rx_q.push_back(dec_sh);
        if (tx !== 1'b1) frame_err <= frame_err + 1;
      end
      dec_cnt <= dec_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct packed {
    logic          rst;
    logic          start;
    logic          tx;
    logic          busy;
    logic          rden;
    logic          done;
    logic [AW-1:0] addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [7:0] first);
    int row;
    int pos;
    row = k / (RL + 2);
    pos = k % (RL + 2);
    if (k == 0) return first;
    if (pos == RL) return 8'h0D;
    if (pos == RL + 1) return 8'h0A;
    return 8'(row * RL + pos);
  endfunction

  task automatic check_stream(input logic [7:0] first, input string tag);
    chk($sformatf("%s byte count", tag), 64'(rx_q.size()), 64'(NBYTES));
    for (int k = 0; k < NBYTES && k < rx_q.size(); k++)
      chk($sformatf("%s byte %0d", tag, k), 64'(rx_q[k]), 64'(exp_byte(k, first)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [7];
    bit         ok;
    bit         found;
    int         base_f;
    int         dc;
    int         first_low;
    logic       trace [45];
    logic [39:0] act_w;
    logic [39:0] exp_w;
    logic [7:0] a5;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    rst   = 1'b1;
    start = 1'b0;

    //            rst   start tx    busy  rden  done  addr
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0};

    for (int v = 0; v < 7; v++) begin
      rst   = vecs[v].rst;
      start = vecs[v].start;
      cyc();
      chk($sformatf("vec%0d tx/busy/rden/done/addr", v),
          64'({tx, busy, read_enable, done, rd_addr}),
          64'({vecs[v].tx, vecs[v].busy, vecs[v].rden, vecs[v].done, vecs[v].addr}));
    end
    start = 1'b0;

    // Full dump of document[i]=i
    wait_done(ok);
    if (ok) begin
      chk("dump1 busy at done", 64'(busy), 64'(1));
      chk("dump1 final addr", 64'(rd_addr), 64'(DEPTH - 1));
      cyc();
      chk("dump1 busy/rden/done after", 64'({busy, read_enable, done}), 64'(0));
    end
    check_stream(8'h00, "dump1");
    chk("dump1 done count", 64'(done_cnt), 64'(1));

    // Bit timing of 0xA5, then reset during the third frame's data bits
    mem[0] = 8'hA5;
    a5     = 8'hA5;
    rx_q.delete();
    base_f = frames_started;
    start  = 1'b1;
    cyc();
    start    = 1'b0;
    trace[0] = tx;
    for (int j = 1; j < 45; j++) begin
      cyc();
      trace[j] = tx;
    end
    first_low = -1;
    for (int j = 0; j < 45; j++)
      if (trace[j] == 1'b0 && first_low < 0) first_low = j;
    chk("a5 start latency", 64'(first_low), 64'(2));
    for (int s = 0; s < 40; s++) begin
      act_w[s] = trace[2 + s];
      if (s / CPB == 0)      exp_w[s] = 1'b0;
      else if (s / CPB == 9) exp_w[s] = 1'b1;
      else                   exp_w[s] = a5[s / CPB - 1];
    end
    chk("a5 frame waveform", 64'(act_w), 64'(exp_w));

    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (frames_started == base_f + 3 && dec_active && dec_cnt >= 12 && dec_cnt <= 20) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk("reach byte3 data", 64'(found), 64'(1));
    dc  = done_cnt;
    rst = 1'b1;
    cyc();
    chk("abort tx/busy/rden/done/addr", 64'({tx, busy, read_enable, done, rd_addr}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 9'd0}));
    rst = 1'b0;
    chk("abort bytes received", 64'(rx_q.size()), 64'(2));
    if (rx_q.size() >= 2) begin
      chk("abort byte0", 64'(rx_q[0]), 64'(8'hA5));
      chk("abort byte1", 64'(rx_q[1]), 64'(8'h01));
    end
    repeat (100) cyc();
    chk("no done after abort", 64'(done_cnt), 64'(dc));
    chk("idle after abort", 64'({tx, busy}), 64'({1'b1, 1'b0}));

    // New dump from address 0 with start pulses every 50 cycles while busy
    mem[0] = 8'h00;
    rx_q.delete();
    start  = 1'b1;
    cyc();
    start  = 1'b0;
    chk("restart busy/rden/addr", 64'({busy, read_enable, rd_addr}), 64'({1'b1, 1'b1, 9'd0}));
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      start = ((c % 50) == 49);
      cyc();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL dump3 done: got timeout expected done pulse");
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start at done ignored", 64'({busy, read_enable, done}), 64'(0));
    chk("dump3 done count", 64'(done_cnt - dc), 64'(1));
    check_stream(8'h00, "dump3");
    rx_q.delete();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start 2 cycles after done", 64'({busy, read_enable, rd_addr}), 64'({1'b1, 1'b1, 9'd0}));

    wait_done(ok);
    if (ok) begin
      cyc();
      chk("dump4 busy after", 64'({busy, read_enable, done}), 64'(0));
    end
    check_stream(8'h00, "dump4");
    chk("dump4 done count", 64'(done_cnt - dc), 64'(2));
    chk("stop bit errors", 64'(frame_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_doc_tx.md
UART_DOC_TX -- requirements
Module: uart_doc_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clk cycles per UART bit (25 MHz / 115200 baud).
REQ-002 Parameter ADDR_W, default 9, document address width.
REQ-003 Parameter DOC_DEPTH, default 512, number of document characters sent per dump.
REQ-004 Parameter ROW_LEN, default 32, characters per document row.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle dump request (debounced, one-pulsed send button).
REQ-008 rd_addr  output  ADDR_W  document read address.
REQ-009 rd_data  input  8  document character at rd_addr (asynchronous-read RAM port).
REQ-010 read_enable  output  1  high for the whole dump; grants the document read port to this block.
REQ-011 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-012 busy  output  1  high from accepted start until dump completes.
REQ-013 done  output  1  one-cycle pulse after the final stop bit; clears the document.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, STOP, NEXT, FINISH.
REQ-015 IDLE: tx=1, busy=0, read_enable=0; start=1 -> FETCH with char index=0, column=0, rd_addr=0, busy=1, read_enable=1 next cycle.
REQ-016 FETCH SHALL hold rd_addr stable for one full cycle; LOAD captures rd_data into the shift register on the following edge (one-cycle read latency tolerated).
REQ-017 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
REQ-018 DATA SHALL drive shift-register bits 0..7, LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-019 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles; a full frame is 10*CLKS_PER_BIT cycles.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reload to 0 at each bit boundary; no fractional accumulation.
REQ-021 After each document character, column SHALL increment; when column reaches ROW_LEN, the block SHALL send 0x0D then 0x0A (no memory read) and reset column to 0.
REQ-022 NEXT SHALL increment rd_addr and return to FETCH while characters remain; after character DOC_DEPTH-1 and its CR/LF -> FINISH.
REQ-023 Total bytes per dump SHALL be DOC_DEPTH + 2*(DOC_DEPTH/ROW_LEN); DOC_DEPTH SHALL be a multiple of ROW_LEN.
REQ-024 FINISH SHALL assert done for exactly one cycle, deassert busy and read_enable on the next edge, and enter IDLE.
REQ-025 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-026 start in the same cycle as the done pulse SHALL be ignored; a new dump is accepted from IDLE only.
REQ-027 rd_addr SHALL not wrap during a dump; its final value is DOC_DEPTH-1.
REQ-028 Byte values SHALL be sent unmodified (0x00 included).
REQ-029 tx SHALL be registered (glitch-free).

Reset
REQ-030 rst=1 SHALL on the next edge force IDLE, tx=1, busy=0, read_enable=0, done=0, rd_addr=0, counters=0.
REQ-031 rst mid-frame SHALL abort the dump without a done pulse; the line returns high immediately, and the document is not cleared.

Verification (CLKS_PER_BIT=4, DOC_DEPTH=64, ROW_LEN=32)
REQ-032 Reset: rst high 2 cycles -> tx=1, busy=0, read_enable=0, done=0, rd_addr=0.
REQ-033 Single dump: document[i]=i, start pulse -> serial decode yields 0x00..0x1F,0x0D,0x0A,0x20..0x3F,0x0D,0x0A (68 bytes, 2720 cycles of frames); done pulses once; busy falls the next cycle.
REQ-034 Bit timing: document[0]=0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
REQ-035 start pulses every 50 cycles during a dump -> the byte stream is identical to REQ-033 and only one done pulse occurs.
REQ-036 rst asserted during the 3rd byte's DATA state -> tx=1 and busy=0 after one edge, no done pulse, and a new start sends from address 0.
REQ-037 start coincident with done -> ignored; a start 2 cycles later begins a full new dump.
